// File: rtl/serial_bus_pkg.sv
// Shared constants and state encoding for the serial bus initiator port.
package serial_bus_pkg;

    localparam int unsigned DEFAULT_ACK_TIMEOUT = 32;

    localparam logic MODE_ADDR = 1'b0;
    localparam logic MODE_DATA = 1'b1;
    localparam logic RW_WRITE  = 1'b1;
    localparam logic RW_READ   = 1'b0;

    typedef logic [3:0] init_state_e;

    localparam init_state_e StIdle    = 4'd0;
    localparam init_state_e StArb     = 4'd1;
    localparam init_state_e StAddr    = 4'd2;
    localparam init_state_e StAckWait = 4'd3;
    localparam init_state_e StWdata   = 4'd4;
    localparam init_state_e StRdata   = 4'd5;
    localparam init_state_e StSplit   = 4'd6;
    localparam init_state_e StResume  = 4'd7;
    localparam init_state_e StDone    = 4'd8;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ser_piso.sv
// Parallel-in serial-out shifter, LSB first; last flags the final bit of the loaded frame.
module ser_piso #(
    parameter int unsigned WIDTH = 17,
    parameter int unsigned CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic [CNT_W-1:0] load_len,
    input  logic             shift,
    output logic             bit_out,
    output logic             last
);

    logic [WIDTH-1:0] sr_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] len_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q  <= '0;
            cnt_q <= '0;
            len_q <= '0;
        end else if (load) begin
            sr_q  <= load_data;
            cnt_q <= '0;
            len_q <= load_len;
        end else if (shift) begin
            sr_q  <= {1'b0, sr_q[WIDTH-1:1]};
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign bit_out = sr_q[0];
    assign last    = (cnt_q == len_q - CNT_W'(1));

endmodule

// File: rtl/serial_init_port.sv
// Initiator-side serial bus port: arbitrate, send address/write data, collect read data.
// Optional even parity on every frame when SER_INIT_PARITY_EN is defined.
module serial_init_port
    import serial_bus_pkg::*;
#(
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned ACK_TIMEOUT = DEFAULT_ACK_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_rw,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              arb_req,
    input  logic              arb_grant,
    output logic              bus_tx,
    output logic              bus_tx_valid,
    output logic              bus_mode,
    output logic              bus_rw,
    input  logic              bus_rx,
    input  logic              bus_rx_valid,
    input  logic              tgt_ack,
    input  logic              tgt_split
);

`ifdef SER_INIT_PARITY_EN
    localparam int unsigned PAR_BITS = 1;
`else
    localparam int unsigned PAR_BITS = 0;
`endif
    localparam int unsigned FRAME_W = max_u(ADDR_W, DATA_W) + 1;
    localparam int unsigned CNT_W   = $clog2(max_u(ADDR_W, DATA_W) + 2);
    localparam int unsigned TMR_W   = $clog2(ACK_TIMEOUT + 1);

    init_state_e       state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              rw_q;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic [TMR_W-1:0]  tmr_q, tmr_d;
    logic [CNT_W-1:0]  rx_cnt_q, rx_cnt_d;

    logic               piso_load, piso_bit, piso_last;
    logic [FRAME_W-1:0] piso_data;
    logic [CNT_W-1:0]   piso_len;
    logic [FRAME_W-1:0] addr_frame, data_frame;

    always_comb begin
        addr_frame = FRAME_W'(addr_q);
        data_frame = FRAME_W'(wdata_q);
`ifdef SER_INIT_PARITY_EN
        addr_frame[ADDR_W] = ^addr_q;
        data_frame[DATA_W] = ^wdata_q;
`endif
    end

    always_comb begin
        state_d   = state_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        tmr_d     = tmr_q;
        rx_cnt_d  = rx_cnt_q;
        piso_load = 1'b0;
        piso_data = addr_frame;
        piso_len  = CNT_W'(ADDR_W + PAR_BITS);
        unique case (state_q)
            StIdle: if (req_valid) begin
                state_d = StArb;
                rdata_d = '0;
                err_d   = 1'b0;
            end
            StArb: if (arb_grant) begin
                state_d   = StAddr;
                piso_load = 1'b1;
            end
            StAddr: if (piso_last) begin
                state_d = StAckWait;
                tmr_d   = '0;
            end
            StAckWait, StResume: begin
                // Ack (or a re-grant after split) starts the data phase; ack beats split.
                if ((state_q == StAckWait && tgt_ack) || (state_q == StResume && arb_grant)) begin
                    state_d   = (rw_q == RW_WRITE) ? StWdata : StRdata;
                    piso_load = (rw_q == RW_WRITE);
                    piso_data = data_frame;
                    piso_len  = CNT_W'(DATA_W + PAR_BITS);
                    tmr_d     = '0;
                    rx_cnt_d  = '0;
                end else if (state_q == StAckWait && tgt_split) begin
                    state_d = StSplit;
                end else if (state_q == StAckWait) begin
                    if (tmr_q == TMR_W'(ACK_TIMEOUT - 1)) begin
                        state_d = StDone;
                        err_d   = 1'b1;
                    end else begin
                        tmr_d = tmr_q + TMR_W'(1);
                    end
                end
            end
            StWdata: if (piso_last) state_d = StDone;
            StRdata: begin
                if (bus_rx_valid) begin
                    tmr_d    = '0;
                    rx_cnt_d = rx_cnt_q + CNT_W'(1);
                    for (int unsigned i = 0; i < DATA_W; i++) begin
                        if (rx_cnt_q == CNT_W'(i)) rdata_d[i] = bus_rx;
                    end
`ifdef SER_INIT_PARITY_EN
                    if (rx_cnt_q == CNT_W'(DATA_W) && bus_rx != ^rdata_q) err_d = 1'b1;
`endif
                    if (rx_cnt_q == CNT_W'(DATA_W + PAR_BITS - 1)) state_d = StDone;
                end else if (tmr_q == TMR_W'(ACK_TIMEOUT - 1)) begin
                    state_d = StDone;
                    err_d   = 1'b1;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            StSplit: if (tgt_ack) state_d = StResume;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            addr_q   <= '0;
            wdata_q  <= '0;
            rw_q     <= 1'b0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            tmr_q    <= '0;
            rx_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            tmr_q    <= tmr_d;
            rx_cnt_q <= rx_cnt_d;
            if (state_q == StIdle && req_valid) begin
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                rw_q    <= req_rw;
            end
        end
    end

    ser_piso #(
        .WIDTH (FRAME_W),
        .CNT_W (CNT_W)
    ) u_piso (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (piso_load),
        .load_data (piso_data),
        .load_len  (piso_len),
        .shift     (bus_tx_valid),
        .bit_out   (piso_bit),
        .last      (piso_last)
    );

    assign req_ready    = (state_q == StIdle);
    assign rsp_valid    = (state_q == StDone);
    assign rsp_rdata    = rdata_q;
    assign rsp_err      = err_q;
    assign arb_req      = (state_q == StArb) || (state_q == StAddr) || (state_q == StAckWait) ||
                          (state_q == StWdata) || (state_q == StRdata) || (state_q == StResume);
    assign bus_tx_valid = (state_q == StAddr) || (state_q == StWdata);
    assign bus_tx       = bus_tx_valid & piso_bit;
    assign bus_mode     = (state_q == StWdata || state_q == StRdata) ? MODE_DATA : MODE_ADDR;
    assign bus_rw       = arb_req & rw_q;

endmodule

// File: tb/tb_serial_init_port.sv
// Scoreboard bench for serial_init_port: expected tx bits and responses are queued by the
// stimulus and popped by independent monitors on the falling clock edge.
module tb_serial_init_port;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0, req_ready, req_rw = 1'b0;
    logic [15:0] req_addr = '0;
    logic [7:0]  req_wdata = '0;
    logic        rsp_valid, rsp_err;
    logic [7:0]  rsp_rdata;
    logic        arb_req, arb_grant = 1'b0;
    logic        bus_tx, bus_tx_valid, bus_mode, bus_rw;
    logic        bus_rx = 1'b0, bus_rx_valid = 1'b0, tgt_ack = 1'b0, tgt_split = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    logic [2:0] tx_q[$];   // {rw, mode, bit}
    logic [8:0] rsp_q[$];  // {err, rdata}

    serial_init_port #(
        .ADDR_W      (16),
        .DATA_W      (8),
        .ACK_TIMEOUT (32)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_rw       (req_rw),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .arb_req      (arb_req),
        .arb_grant    (arb_grant),
        .bus_tx       (bus_tx),
        .bus_tx_valid (bus_tx_valid),
        .bus_mode     (bus_mode),
        .bus_rw       (bus_rw),
        .bus_rx       (bus_rx),
        .bus_rx_valid (bus_rx_valid),
        .tgt_ack      (tgt_ack),
        .tgt_split    (tgt_split)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // tx monitor
    always @(negedge clk) begin
        if (rst_n && bus_tx_valid) begin
            if (tx_q.size() == 0) begin
                check("unexpected_tx_bit", {29'd0, bus_rw, bus_mode, bus_tx}, 32'hFFFF_FFFF);
            end else begin
                logic [2:0] e;
                e = tx_q.pop_front();
                check("tx_bit", {29'd0, bus_rw, bus_mode, bus_tx}, {29'd0, e});
            end
        end
    end

    // response monitor
    always @(negedge clk) begin
        if (rst_n && rsp_valid) begin
            if (rsp_q.size() == 0) begin
                check("unexpected_rsp", {23'd0, rsp_err, rsp_rdata}, 32'hFFFF_FFFF);
            end else begin
                logic [8:0] e;
                e = rsp_q.pop_front();
                check("rsp", {23'd0, rsp_err, rsp_rdata}, {23'd0, e});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_frame(input logic [15:0] v, input int w, input logic mode,
                              input logic rw);
        logic p;
        p = 1'b0;
        for (int i = 0; i < w; i++) begin
            tx_q.push_back({rw, mode, v[i]});
            p = p ^ v[i];
        end
`ifdef SER_INIT_PARITY_EN
        tx_q.push_back({rw, mode, p});
`endif
    endtask

    task automatic issue(input logic rw, input logic [15:0] a, input logic [7:0] d);
        int n;
        n = 0;
        while (!req_ready && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) check("req_ready_timeout", 0, 1);
        req_valid = 1'b1;
        req_rw    = rw;
        req_addr  = a;
        req_wdata = d;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic grant_after(input int n);
        repeat (n) tick();
        arb_grant = 1'b1;
        tick();
        arb_grant = 1'b0;
    endtask

    task automatic ack_after(input int n);
        repeat (n) tick();
        tgt_ack = 1'b1;
        tick();
        tgt_ack = 1'b0;
    endtask

    task automatic wait_tx(input logic lvl);
        int n;
        n = 0;
        while (bus_tx_valid !== lvl && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) check("wait_tx_timeout", 0, 1);
    endtask

    task automatic wait_rsp();
        int n;
        n = 0;
        while (!rsp_valid && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) check("wait_rsp_timeout", 0, 1);
    endtask

    task automatic send_rx(input logic [7:0] d, input logic par);
        for (int i = 0; i < 8; i++) begin
            repeat ((i * 3 + 1) % 4) tick();
            bus_rx_valid = 1'b1;
            bus_rx       = d[i];
            tick();
            bus_rx_valid = 1'b0;
            bus_rx       = 1'b0;
        end
`ifdef SER_INIT_PARITY_EN
        bus_rx_valid = 1'b1;
        bus_rx       = par;
        tick();
        bus_rx_valid = 1'b0;
        bus_rx       = 1'b0;
`else
        if (par === 1'bx) $display("unused parity argument");
`endif
    endtask

    task automatic check_quiet(input string name);
        check({name, "_outs"}, {26'd0, arb_req, bus_tx_valid, bus_tx, bus_mode, bus_rw, rsp_valid},
              32'd0);
        check({name, "_rsp"}, {23'd0, rsp_err, rsp_rdata}, 32'd0);
        check({name, "_ready"}, {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        logic [15:0] seq_a;
        logic [7:0]  seq_d;
        int          n;

        #1;
        check_quiet("reset");
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // 1: write A5C3 / 3C, hand-derived LSB-first bit order (first bit is MSB of seq)
        seq_a = 16'b1100_0011_1010_0101;
        seq_d = 8'b0011_1100;
        for (int i = 15; i >= 0; i--) tx_q.push_back({1'b1, 1'b0, seq_a[i]});
`ifdef SER_INIT_PARITY_EN
        tx_q.push_back(3'b100);
`endif
        for (int i = 7; i >= 0; i--) tx_q.push_back({1'b1, 1'b1, seq_d[i]});
`ifdef SER_INIT_PARITY_EN
        tx_q.push_back(3'b110);
`endif
        rsp_q.push_back({1'b0, 8'h00});
        issue(1'b1, 16'hA5C3, 8'h3C);
        check("arb_req_in_arb", {31'd0, arb_req}, 32'd1);
        grant_after(2);
        wait_tx(1'b1);
        wait_tx(1'b0);
        ack_after(3);
        wait_rsp();
        check("arb_req_done", {31'd0, arb_req}, 32'd0);
        tick();
        check("arb_req_after", {31'd0, arb_req}, 32'd0);
        check("ready_after_wr", {31'd0, req_ready}, 32'd1);

        // 2: read 81 with idle gaps
        push_frame(16'h0F0F, 16, 1'b0, 1'b0);
        rsp_q.push_back({1'b0, 8'h81});
        issue(1'b0, 16'h0F0F, 8'hEE);
        grant_after(1);
        wait_tx(1'b1);
        wait_tx(1'b0);
        ack_after(0);
        check("mode_rdata", {31'd0, bus_mode}, 32'd1);
        send_rx(8'h81, 1'b0);
        wait_rsp();
        tick();

        // 3: no ack -> timeout after ACK_TIMEOUT cycles in ACK_WAIT
        push_frame(16'h0001, 16, 1'b0, 1'b0);
        rsp_q.push_back({1'b1, 8'h00});
        issue(1'b0, 16'h0001, 8'h00);
        grant_after(1);
        wait_tx(1'b1);
        wait_tx(1'b0);
        n = 0;
        while (!rsp_valid && n < 200) begin
            n++;
            tick();
        end
        check("timeout_cycles", n, 32);
        tick();
        check("ready_after_to", {31'd0, req_ready}, 32'd1);

        // 4: split then resume, no re-address
        push_frame(16'h8001, 16, 1'b0, 1'b0);
        rsp_q.push_back({1'b0, 8'h5A});
        issue(1'b0, 16'h8001, 8'h00);
        grant_after(2);
        wait_tx(1'b1);
        wait_tx(1'b0);
        repeat (2) tick();
        tgt_split = 1'b1;
        tick();
        tgt_split = 1'b0;
        check("split_arb_req", {31'd0, arb_req}, 32'd0);
        repeat (19) tick();
        check("split_arb_req_hold", {31'd0, arb_req}, 32'd0);
        tgt_ack = 1'b1;
        tick();
        tgt_ack = 1'b0;
        check("resume_arb_req", {31'd0, arb_req}, 32'd1);
        grant_after(2);
        send_rx(8'h5A, 1'b0);
        wait_rsp();
        tick();

        // 5: reset during address bit 7
        push_frame(16'hFFFF, 16, 1'b0, 1'b1);
        issue(1'b1, 16'hFFFF, 8'hFF);
        grant_after(0);
        wait_tx(1'b1);
        repeat (7) tick();
        rst_n = 1'b0;
        #1;
        check_quiet("abort");
        tx_q.delete();
        rsp_q.delete();
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        check("ready_after_abort", {31'd0, req_ready}, 32'd1);
        push_frame(16'h1234, 16, 1'b0, 1'b1);
        push_frame(16'h00F0, 8, 1'b1, 1'b1);
        rsp_q.push_back({1'b0, 8'h00});
        issue(1'b1, 16'h1234, 8'hF0);
        grant_after(1);
        wait_tx(1'b1);
        wait_tx(1'b0);
        ack_after(1);
        wait_rsp();
        tick();

`ifdef SER_INIT_PARITY_EN
        // 6: parity bit on write data, parity error on read
        push_frame(16'h0002, 16, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) tx_q.push_back({1'b1, 1'b1, (i < 3) ? 1'b1 : 1'b0});
        tx_q.push_back(3'b111);
        rsp_q.push_back({1'b0, 8'h00});
        issue(1'b1, 16'h0002, 8'h07);
        grant_after(1);
        wait_tx(1'b1);
        wait_tx(1'b0);
        ack_after(1);
        wait_rsp();
        tick();
        push_frame(16'h0003, 16, 1'b0, 1'b0);
        rsp_q.push_back({1'b1, 8'h81});
        issue(1'b0, 16'h0003, 8'h00);
        grant_after(1);
        wait_tx(1'b1);
        wait_tx(1'b0);
        ack_after(0);
        send_rx(8'h81, 1'b1);
        wait_rsp();
        tick();
`endif

        repeat (3) tick();
        check("tx_q_drained", tx_q.size(), 0);
        check("rsp_q_drained", rsp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1);
    end

endmodule
